sm4_key_sched_ctrl: RTL and testbench

// - Sequences SM4 key expansion. Loads MK, drives the round-constant ROM get_cki
//   (instantiated inside; 1-cycle registered read), runs 32 rounds at 1 round/cycle
//   and streams rk[0..31] to the cipher core over a valid/ready handshake.
// - S-box is external and shared: the block drives tau_in and takes tau_out back

---
 rtl/sm4_key_sched_ctrl.sv | 175 +++++++++++++++++
 tb/tb_sm4_key_sched_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sm4_key_sched_ctrl.sv
// rtl/sm4_key_sched_ctrl.sv - SM4 key expansion sequencer with streamed round keys
// Optional 32-entry round-key buffer enabled by defining SM4_KEY_BUF_EN.

module sm4_get_cki (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [4:0]  addr,
    output logic [31:0] cki_out
);
    // CK byte j of round i is (4*i+j)*7 mod 256
    function automatic logic [31:0] ck_of(input logic [4:0] i);
        logic [31:0] v;
        logic [7:0]  n;
        v = '0;
        for (int j = 0; j < 4; j++) begin
            n = {1'b0, i, 2'(j)};
            v[31 - 8*j -: 8] = n * 8'd7;
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            cki_out <= '0;
        end else if (en) begin
            cki_out <= ck_of(addr);
        end
    end
endmodule

module sm4_key_sched_ctrl #(
    parameter int NROUNDS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] mk,
    output logic         busy,
    output logic [31:0]  tau_in,
    input  logic [31:0]  tau_out,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [31:0]  rk_out,
    output logic [4:0]   rk_idx,
    output logic         done,
    input  logic [4:0]   rk_rd_addr,
    output logic [31:0]  rk_rd_data,
    output logic         key_buf_vld
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    localparam logic [4:0] LAST = 5'(NROUNDS - 1);

    state_t      state_q, state_d;
    logic [31:0] k0, k1, k2, k3;
    logic [4:0]  idx;
    logic [4:0]  r;
    logic [31:0] cki_out;
    logic [31:0] new_k;
    logic        adv, run_adv, start_acc, rom_en;

    function automatic logic [31:0] l_prime(input logic [31:0] b);
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    assign busy      = (state_q != IDLE);
    assign tau_in    = k1 ^ k2 ^ k3 ^ cki_out;
    assign new_k     = k0 ^ l_prime(tau_out);
    assign adv       = ~rk_valid | rk_ready;
    assign run_adv   = (state_q == RUN) & adv;
    assign start_acc = (state_q == IDLE) & start;
    // ROM only re-reads when a round is consumed, so CK[r] survives a stall
    assign rom_en    = (state_q == LOAD) | run_adv;

    sm4_get_cki u_get_cki (
        .clk     (clk),
        .rst     (rst),
        .en      (rom_en),
        .addr    (idx),
        .cki_out (cki_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = RUN;
            RUN:     if (adv && (r == LAST)) state_d = DRAIN;
            DRAIN:   if (rk_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k0       <= '0;
            k1       <= '0;
            k2       <= '0;
            k3       <= '0;
            idx      <= '0;
            r        <= '0;
            rk_out   <= '0;
            rk_idx   <= '0;
            rk_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start_acc) begin
                k0  <= mk[127:96] ^ 32'hA3B1BAC6;
                k1  <= mk[95:64]  ^ 32'h56AA3350;
                k2  <= mk[63:32]  ^ 32'h677D9197;
                k3  <= mk[31:0]   ^ 32'hB27022DC;
                idx <= '0;
                r   <= '0;
            end
            if (state_q == LOAD) begin
                idx <= idx + 5'd1;
            end
            if (run_adv) begin
                k0       <= k1;
                k1       <= k2;
                k2       <= k3;
                k3       <= new_k;
                rk_out   <= new_k;
                rk_idx   <= r;
                rk_valid <= 1'b1;
                r        <= r + 5'd1;
                idx      <= idx + 5'd1;
            end
            if ((state_q == DRAIN) && rk_ready) begin
                rk_valid <= 1'b0;
                done     <= 1'b1;
            end
        end
    end

`ifdef SM4_KEY_BUF_EN
    logic [31:0] key_buf [32];

    always_ff @(posedge clk) begin
        if (run_adv) begin
            key_buf[r] <= new_k;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rk_rd_data  <= '0;
            key_buf_vld <= 1'b0;
        end else begin
            rk_rd_data <= key_buf[rk_rd_addr];
            if (start_acc) begin
                key_buf_vld <= 1'b0;
            end else if ((state_q == DRAIN) && rk_ready) begin
                key_buf_vld <= 1'b1;
            end
        end
    end
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rk_rd_addr;
    assign rk_rd_data     = '0;
    assign key_buf_vld    = 1'b0;
`endif

endmodule

// File: tb/tb_sm4_key_sched_ctrl.sv
// tb/tb_sm4_key_sched_ctrl.sv - self-checking bench for sm4_key_sched_ctrl
// Provides the external S-box and a reference SM4 key expansion model.

module tb_sm4_key_sched_ctrl;
    localparam logic [127:0] STD_MK = 128'h0123456789ABCDEFFEDCBA9876543210;

    localparam logic [127:0] SBOX_ROWS [16] = '{
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    typedef struct {
        logic [127:0] mk;
        int           mode;
        bit           lat;
        bit           kat;
        logic [31:0]  e0;
        logic [31:0]  e1;
        logic [31:0]  e31;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] mk;
    logic         busy;
    logic [31:0]  tau_in;
    logic [31:0]  tau_out;
    logic         rk_valid;
    logic         rk_ready;
    logic [31:0]  rk_out;
    logic [4:0]   rk_idx;
    logic         done;
    logic [4:0]   rk_rd_addr;
    logic [31:0]  rk_rd_data;
    logic         key_buf_vld;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rk [32];
    logic [31:0] got_rk [32];

    always #5 clk = ~clk;

    sm4_key_sched_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mk          (mk),
        .busy        (busy),
        .tau_in      (tau_in),
        .tau_out     (tau_out),
        .rk_valid    (rk_valid),
        .rk_ready    (rk_ready),
        .rk_out      (rk_out),
        .rk_idx      (rk_idx),
        .done        (done),
        .rk_rd_addr  (rk_rd_addr),
        .rk_rd_data  (rk_rd_data),
        .key_buf_vld (key_buf_vld)
    );

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [127:0] row;
        row = SBOX_ROWS[x[7:4]];
        return row[8*(15 - int'(x[3:0])) +: 8];
    endfunction

    function automatic logic [31:0] sbox4(input logic [31:0] x);
        return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
    endfunction

    always_comb tau_out = sbox4(tau_in);

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic ref_expand(input logic [127:0] k);
        logic [31:0] kk [36];
        logic [31:0] ck, t;
        logic [7:0]  cb;
        kk[0] = k[127:96] ^ 32'hA3B1BAC6;
        kk[1] = k[95:64]  ^ 32'h56AA3350;
        kk[2] = k[63:32]  ^ 32'h677D9197;
        kk[3] = k[31:0]   ^ 32'hB27022DC;
        cb = 8'd0;
        for (int i = 0; i < 32; i++) begin
            ck = '0;
            for (int j = 0; j < 4; j++) begin
                ck = {ck[23:0], cb};
                cb = cb + 8'd7;
            end
            t = sbox4(kk[i+1] ^ kk[i+2] ^ kk[i+3] ^ ck);
            t = t ^ ((t << 13) | (t >> 19)) ^ ((t << 23) | (t >> 9));
            kk[i+4] = kk[i] ^ t;
            exp_rk[i] = kk[i+4];
        end
    endtask

    // mode 0: always ready, 1: random ready, 2: 5-cycle stall at rk_idx 7,
    // 3: extra start pulse while busy. Called at a negedge; returns at the done negedge.
    task automatic run_keys(input logic [127:0] k, input int mode, input bit lat);
        int          cyc, n, first_v, done_c, stall_left;
        bit          stalled;
        logic [31:0] held_out;
        ref_expand(k);
        cyc = 0; n = 0; first_v = -1; done_c = -1; stall_left = 0; stalled = 0;
        held_out = '0;
        mk = k;
        start = 1'b1;
        rk_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        while (done_c < 0 && cyc < 600) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (mode == 3 && cyc == 10) begin
                start = 1'b1;
                mk = ~k;
            end
`ifdef SM4_KEY_BUF_EN
            if (cyc == 1) chk("key_buf_vld_cleared", 32'(key_buf_vld), 32'd0);
`endif
            if (done) begin
                done_c = cyc;
                chk("busy_at_done", 32'(busy), 32'd0);
                chk("rk_valid_at_done", 32'(rk_valid), 32'd0);
            end else begin
                if (stall_left > 0) begin
                    rk_ready = 1'b0;
                    chk("stall_rk_out", rk_out, held_out);
                    chk("stall_rk_idx", 32'(rk_idx), 32'd7);
                    chk("stall_rk_valid", 32'(rk_valid), 32'd1);
                    stall_left--;
                end else if (mode == 2 && !stalled && rk_valid && rk_idx == 5'd7) begin
                    held_out = rk_out;
                    rk_ready = 1'b0;
                    stall_left = 4;
                    stalled = 1'b1;
                end else if (mode == 1) begin
                    rk_ready = 1'($urandom_range(0, 1));
                end else begin
                    rk_ready = 1'b1;
                end
                if (rk_valid && rk_ready) begin
                    if (n < 32) begin
                        chk("rk_idx", 32'(rk_idx), 32'(n));
                        chk("rk_out", rk_out, exp_rk[n]);
                        got_rk[n] = rk_out;
                        if (n == 0) first_v = cyc;
                    end
                    n++;
                end
            end
        end
        chk("key_count", 32'(n), 32'd32);
        chk("done_seen", 32'(done_c >= 0), 32'd1);
        if (lat) begin
            chk("rk0_cycle", 32'(first_v), 32'd3);
            chk("done_cycle", 32'(done_c), 32'd35);
        end
        if (mode == 2) chk("stall_happened", 32'(stalled), 32'd1);
    endtask

    initial begin
        vec_t vt [7];
        bit   found;
        bit   valid_seen;

        vt[0] = '{STD_MK, 0, 1'b1, 1'b1, 32'hF12186F9, 32'h41662B61, 32'h9124A012};
        vt[1] = '{STD_MK, 2, 1'b0, 1'b1, 32'hF12186F9, 32'h41662B61, 32'h9124A012};
        vt[2] = '{STD_MK, 3, 1'b0, 1'b1, 32'hF12186F9, 32'h41662B61, 32'h9124A012};
        vt[3] = '{128'h0, 1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        vt[4] = '{{128{1'b1}}, 1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0};
        vt[5] = '{STD_MK, 1, 1'b0, 1'b1, 32'hF12186F9, 32'h41662B61, 32'h9124A012};
        vt[6] = '{STD_MK, 0, 1'b1, 1'b1, 32'hF12186F9, 32'h41662B61, 32'h9124A012};

        rst = 1'b1; start = 1'b0; mk = '0; rk_ready = 1'b0; rk_rd_addr = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rk_valid", 32'(rk_valid), 32'd0);
        chk("reset_rk_out", rk_out, 32'd0);
        chk("reset_rk_idx", 32'(rk_idx), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_key_buf_vld", 32'(key_buf_vld), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            run_keys(vt[v].mk, vt[v].mode, vt[v].lat);
            if (vt[v].kat) begin
                chk("kat_rk0", got_rk[0], vt[v].e0);
                chk("kat_rk1", got_rk[1], vt[v].e1);
                chk("kat_rk31", got_rk[31], vt[v].e31);
            end
        end

`ifdef SM4_KEY_BUF_EN
        rk_rd_addr = 5'd0;
        @(negedge clk);
        chk("buf_rd_0", rk_rd_data, 32'hF12186F9);
        rk_rd_addr = 5'd31;
        @(negedge clk);
        chk("buf_rd_31", rk_rd_data, 32'h9124A012);
        chk("key_buf_vld_set", 32'(key_buf_vld), 32'd1);
`else
        rk_rd_addr = 5'd31;
        @(negedge clk);
        chk("nobuf_rd_data", rk_rd_data, 32'd0);
        chk("nobuf_key_buf_vld", 32'(key_buf_vld), 32'd0);
`endif

        mk = STD_MK; start = 1'b1; rk_ready = 1'b1; found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (rk_valid && rk_idx == 5'd12) found = 1'b1;
        end
        chk("reached_idx12", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rk_valid", 32'(rk_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        valid_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rk_valid || busy) valid_seen = 1'b1;
        end
        chk("abort_quiet", 32'(valid_seen), 32'd0);
        run_keys(STD_MK, 0, 1'b1);

        for (int t = 0; t < 100; t++) begin
            run_keys({$urandom, $urandom, $urandom, $urandom}, 1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
